fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 Stall  in  1  1 = decode register holding, so outputs must not advance; 0 = advance.
REQ-005 BranchTaken  in  1  redirect request from execute; priority over Stall.
REQ-006 BranchTarget  in  32  redirect address, valid while BranchTaken=1.
REQ-007 imem_req  out  1  instruction memory request.
REQ-008 imem_addr  out  32  request address, stable while imem_req=1.
REQ-009 imem_ready  in  1  one-cycle response strobe; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  in  32  fetched instruction word.
REQ-011 PC_fe, PCP4_fe, Inst_fe  out  32 each  registered instruction bundle feeding the decode register.
REQ-012 Valid_fe  out  1  1 = bundle holds a real instruction; 0 = bubble.
REQ-013 FetchErr  out  1  sticky misaligned-redirect flag.

Function
REQ-014 The FSM SHALL have states FETCH, HOLD and FLUSH.
REQ-015 In FETCH, imem_req=1 and imem_addr=ReqAddr; a request, once raised, SHALL stay high with a constant address until imem_ready.
REQ-016 On FETCH with imem_ready=1, BranchTaken=0 and Stall=0, the bundle SHALL load {PC, PC+4, imem_rdata, Valid=1}. ReqAddr SHALL load PC+4 at the same edge. The state SHALL stay FETCH.
REQ-017 On FETCH with imem_ready=1, BranchTaken=0 and Stall=1, imem_rdata and its PC SHALL go into the hold buffer. The bundle SHALL be unchanged and the state SHALL become HOLD. imem_req=0 in HOLD.
REQ-018 In HOLD with Stall=0, the bundle SHALL load from the hold buffer with Valid=1. ReqAddr SHALL advance by 4 and the state SHALL return to FETCH.
REQ-019 Any cycle with Stall=0 and no instruction delivered SHALL load a bubble: Inst_fe=32'h0000_0033, Valid_fe=0, PC_fe and PCP4_fe unchanged.
REQ-020 With Stall=1 and BranchTaken=0, the bundle SHALL hold its value.
REQ-021 On BranchTaken=1, the bundle SHALL load a bubble, regardless of Stall. The redirect target SHALL be latched.
REQ-022 Branch in FETCH with imem_ready=1: the response SHALL be discarded. ReqAddr SHALL load the target next cycle and the state SHALL stay FETCH.
REQ-023 Branch in FETCH with imem_ready=0: the state SHALL become FLUSH. The old request stays high until imem_ready. That response SHALL be discarded, then ReqAddr SHALL load the latched target and the state SHALL return to FETCH.
REQ-024 Branch in HOLD: the hold buffer SHALL be dropped. ReqAddr SHALL load the target and the state SHALL become FETCH.
REQ-025 Branch in FLUSH: the latched target SHALL be overwritten by the newest one.
REQ-026 The latency SHALL be one edge from imem_ready to Valid_fe. The throughput SHALL be one instruction per cycle with a zero-wait memory.
REQ-027 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

Reset
REQ-028 With rst_n=0, state SHALL be FETCH, ReqAddr=RESET_PC, imem_req=0, PC_fe=0, PCP4_fe=0, Inst_fe=32'h0000_0033, Valid_fe=0 and FetchErr=0.
REQ-029 After rst_n deasserts, imem_req SHALL go to 1 in the first cycle. Reset during an outstanding request SHALL abandon that request, and a late imem_ready SHALL be ignored until imem_req is re-raised.

Configuration
REQ-030 With FETCH_MISALIGN_CHK_EN defined, a redirect with BranchTarget[1:0]!=0 SHALL use {BranchTarget[31:2],2'b00} and set FetchErr until reset.
REQ-031 Without FETCH_MISALIGN_CHK_EN, BranchTarget SHALL be used unmodified and FetchErr SHALL be tied to 0.

Structure
REQ-032 Package fetch_pkg SHALL hold the NOP constant 32'h0000_0033, the state enum and the RESET_PC default.
REQ-033 The block SHALL be one module with no sub-module; the hold buffer and FSM are small enough to stay inline.

Verification
REQ-034 Reset, then zero-wait memory returning 0xA0,0xA1,0xA2 -> imem_addr 0,4,8. Bundles (0,4,0xA0,1), (4,8,0xA1,1), (8,0xC,0xA2,1) on consecutive cycles.
REQ-035 Stall=1 for 3 cycles as 0xA1 returns at PC 4 -> bundle stays (0,4,0xA0). After release, (4,8,0xA1,1) with no repeated imem_req for PC 4.
REQ-036 BranchTaken=1, target 0x100, memory 3-cycle latency, request for 8 outstanding -> FLUSH, and the PC 8 data never appears. The next imem_addr is 0x100, and only bubbles (0x33, Valid 0) appear until then.
REQ-037 BranchTaken=1 and Stall=1 in the same cycle -> a bubble loads, and the next fetch address is the target.
REQ-038 With the macro defined, target 0x102 -> imem_addr 0x100 and FetchErr=1 sticky. Without the macro, imem_addr 0x102 and FetchErr=0.
REQ-039 Assert rst_n=0 with a request outstanding, then release -> all outputs return to reset values, and imem_addr restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// NOP encoding, FSM states, bundle layout and default reset PC.
package fetch_pkg;

  localparam logic [31:0] NOP          = 32'h0000_0033;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [31:0] inst;
    logic        valid;
  } fe_bundle_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem request, stall hold buffer.
// FETCH_MISALIGN_CHK_EN: word-align redirect targets and flag misalignment.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_fe,
  output logic [31:0] PCP4_fe,
  output logic [31:0] Inst_fe,
  output logic        Valid_fe,
  output logic        FetchErr
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] req_addr;
  logic [31:0] tgt_q;
  logic [31:0] tgt;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic        ready;
  fe_bundle_t  bnd;

  // A strobe only counts while our own request is up.
  assign ready = imem_ready & imem_req;

`ifdef FETCH_MISALIGN_CHK_EN
  logic err_q;

  assign tgt = {BranchTarget[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (BranchTaken && (BranchTarget[1:0] != 2'b00))
      err_q <= 1'b1;
  end

  assign FetchErr = err_q;
`else
  assign tgt      = BranchTarget;
  assign FetchErr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= FETCH;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: begin
        if (BranchTaken)
          state_nxt = ready ? FETCH : FLUSH;
        else if (ready && Stall)
          state_nxt = HOLD;
      end
      HOLD: begin
        if (BranchTaken || !Stall)
          state_nxt = FETCH;
      end
      FLUSH: begin
        if (ready)
          state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    imem_req  = rst_n && (state != HOLD);
    imem_addr = req_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr  <= RESET_PC;
      tgt_q     <= RESET_PC;
      hold_pc   <= '0;
      hold_inst <= NOP;
    end else begin
      if (BranchTaken)
        tgt_q <= tgt;
      unique case (state)
        FETCH: begin
          if (BranchTaken) begin
            if (ready)
              req_addr <= tgt;
          end else if (ready && Stall) begin
            hold_pc   <= req_addr;
            hold_inst <= imem_rdata;
          end else if (ready) begin
            req_addr <= req_addr + 32'd4;
          end
        end
        HOLD: begin
          if (BranchTaken)
            req_addr <= tgt;
          else if (!Stall)
            req_addr <= req_addr + 32'd4;
        end
        FLUSH: begin
          // Newest redirect wins if it coincides with the stale response.
          if (ready)
            req_addr <= BranchTaken ? tgt : tgt_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bnd <= '{pc: '0, pcp4: '0, inst: NOP, valid: 1'b0};
    end else if (BranchTaken || !Stall) begin
      if (!BranchTaken && (state == FETCH) && ready) begin
        bnd <= '{pc: req_addr, pcp4: req_addr + 32'd4,
                 inst: imem_rdata, valid: 1'b1};
      end else if (!BranchTaken && (state == HOLD)) begin
        bnd <= '{pc: hold_pc, pcp4: hold_pc + 32'd4,
                 inst: hold_inst, valid: 1'b1};
      end else begin
        bnd.inst  <= NOP;
        bnd.valid <= 1'b0;
      end
    end
  end

  assign PC_fe    = bnd.pc;
  assign PCP4_fe  = bnd.pcp4;
  assign Inst_fe  = bnd.inst;
  assign Valid_fe = bnd.valid;

endmodule
